// File: rtl/float_to_fixed_seq.sv
// Sequential IEEE-754 single -> signed fixed-point (FRAC fractional bits) converter, 5 cycles per result.
// Optional build macro: ROUND_NEAREST_EN (round half away from zero on right shifts; default truncates).
module float_to_fixed_seq #(
    parameter int P    = 32,
    parameter int FRAC = 26
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         BEGIN,
    input  logic [31:0]  FLOAT,
    output logic         READY,
    output logic         VALID,
    output logic [P-1:0] FIXED,
    output logic         OVF,
    output logic         UNF
);

    // Magnitude is kept wide enough that the largest non-saturating left shift never wraps.
    localparam int TW = P + 25;
    localparam logic signed [9:0] SH_BIAS = 10'(150 - FRAC);
    localparam logic signed [9:0] SH_BIG  = 10'(P - 23);
    localparam logic [TW-1:0] LIM     = {{(TW-P){1'b0}}, 1'b1, {(P-1){1'b0}}};
    localparam logic [P-1:0]  MAX_POS = {1'b0, {(P-1){1'b1}}};
    localparam logic [P-1:0]  MIN_NEG = {1'b1, {(P-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_CAPT, S_SHIFT, S_SIGN, S_DONE} state_t;

    state_t             state;
    logic [31:0]        float_q;
    logic               sign_q, exp_zero_q, exp_max_q, mant_nz_q, big_q;
    logic [23:0]        mant_q;
    logic signed [9:0]  sh_q;
    logic [TW-1:0]      mag_q;
    logic [P-1:0]       res_q;
    logic               res_ovf_q, res_unf_q;

    logic [TW-1:0]      mant_ext, mag_next;
    logic [9:0]         rs;
`ifdef ROUND_NEAREST_EN
    logic [TW-1:0]      pre;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        mant_ext = {{(TW-24){1'b0}}, mant_q};
        rs       = -sh_q;
`ifdef ROUND_NEAREST_EN
        pre      = mant_ext >> (rs - 10'd1);
`endif
        if (sh_q >= 10'sd0) begin
            mag_next = mant_ext << sh_q;
        end else begin
`ifdef ROUND_NEAREST_EN
            // pre keeps one extra bit below the LSB; adding it rounds half away from zero.
            mag_next = (pre >> 1) + {{(TW-1){1'b0}}, pre[0]};
`else
            mag_next = mant_ext >> rs;
`endif
        end
    end

    logic [P-1:0] res_next;
    logic         ovf_next, unf_next;

    always_comb begin
        res_next = '0;
        ovf_next = 1'b0;
        unf_next = 1'b0;
        if (exp_max_q) begin
            res_next = sign_q ? MIN_NEG : MAX_POS;
            ovf_next = 1'b1;
        end else if (exp_zero_q) begin
            unf_next = mant_nz_q;
        end else if (big_q || (mag_q > LIM) || ((mag_q == LIM) && !sign_q)) begin
            res_next = sign_q ? MIN_NEG : MAX_POS;
            ovf_next = 1'b1;
        end else if (mag_q == LIM) begin
            // -2^(P-1) is representable exactly, so it is not an overflow.
            res_next = MIN_NEG;
        end else begin
            res_next = sign_q ? -mag_q[P-1:0] : mag_q[P-1:0];
            unf_next = (mag_q == '0);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so stage order inside the block is irrelevant.
    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: only control and visible outputs are reset; datapath registers are always loaded before use.
            state <= S_IDLE;
            READY <= 1'b1;
            VALID <= 1'b0;
            FIXED <= '0;
            OVF   <= 1'b0;
            UNF   <= 1'b0;
        end else begin
            VALID <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (BEGIN) begin
                        float_q <= FLOAT;
                        READY   <= 1'b0;
                        state   <= S_CAPT;
                    end
                end
                S_CAPT: begin
                    sign_q     <= float_q[31];
                    exp_zero_q <= (float_q[30:23] == 8'd0);
                    exp_max_q  <= &float_q[30:23];
                    mant_nz_q  <= |float_q[22:0];
                    mant_q     <= {|float_q[30:23], float_q[22:0]};
                    sh_q       <= $signed({2'b00, float_q[30:23]}) - SH_BIAS;
                    state      <= S_SHIFT;
                end
                S_SHIFT: begin
                    mag_q <= mag_next;
                    big_q <= (sh_q >= SH_BIG);
                    state <= S_SIGN;
                end
                S_SIGN: begin
                    res_q     <= res_next;
                    res_ovf_q <= ovf_next;
                    res_unf_q <= unf_next;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    VALID <= 1'b1;
                    FIXED <= res_q;
                    OVF   <= res_ovf_q;
                    UNF   <= res_unf_q;
                    READY <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_float_to_fixed_seq.sv
// Self-checking bench for float_to_fixed_seq (P=32, FRAC=26): real-valued model, directed vectors, per-cycle compare.
module tb_float_to_fixed_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        begin_in = 1'b0;
    logic [31:0] float_in = '0;
    logic        ready, valid, ovf, unf;
    logic [31:0] fixed;

    float_to_fixed_seq #(.P(32), .FRAC(26)) dut (
        .CLK(clk), .RST(rst), .BEGIN(begin_in), .FLOAT(float_in),
        .READY(ready), .VALID(valid), .FIXED(fixed), .OVF(ovf), .UNF(unf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] fx;
        logic        ov;
        logic        un;
    } res_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    logic rst_seen = 1'b1;
    res_t exp_q[$];
    int   acc_q[$];
    res_t held = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic real pow2(input int k);
        real r = 1.0;
        if (k >= 0) repeat (k) r = r * 2.0;
        else        repeat (-k) r = r / 2.0;
        return r;
    endfunction

    // Value-level model: x = 1.m * 2^(e-127), scaled by 2^26, then truncated/rounded and saturated.
    function automatic res_t model(input logic [31:0] f);
        res_t   r = '0;
        int     e = int'(f[30:23]);
        real    v;
        longint mag;
        if (e == 255) begin
            r.fx = f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            r.ov = 1'b1;
            return r;
        end
        if (e == 0) begin
            r.un = (f[22:0] != 0);
            return r;
        end
        v = real'(int'(f[22:0]) + (1 << 23)) * pow2(e - 150 + 26);
`ifdef ROUND_NEAREST_EN
        v = $floor(v + 0.5);
`else
        v = $floor(v);
`endif
        if (v > pow2(31) || (v == pow2(31) && !f[31])) begin
            r.fx = f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            r.ov = 1'b1;
        end else if (v == pow2(31)) begin
            r.fx = 32'h8000_0000;
        end else begin
            mag  = longint'(v);
            r.fx = f[31] ? 32'(-mag) : 32'(mag);
            r.un = (mag == 0);
        end
        return r;
    endfunction

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    // Compare process: every negedge either reset state, a fresh result, or the held previous result.
    always @(negedge clk) begin
        if (rst_seen) begin
            exp_q.delete();
            acc_q.delete();
            held = '0;
            check("reset_state", 64'({ready, valid, fixed, ovf, unf}), 64'({1'b1, 1'b0, 32'h0, 1'b0, 1'b0}));
        end else if (valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 64'({fixed, ovf, unf}), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                held = exp_q.pop_front();
                check("result", 64'({fixed, ovf, unf}), 64'(held));
                check("latency", 64'(cyc - acc_q.pop_front()), 64'd4);
            end
        end else begin
            check("hold", 64'({fixed, ovf, unf}), 64'(held));
        end
    end

    task automatic start(input logic [31:0] f, output int acc);
        int n = 0;
        acc = -1;
        @(negedge clk);
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            check("ready_timeout", 64'(ready), 64'd1);
            return;
        end
        #1;
        begin_in = 1'b1;
        float_in = f;
        exp_q.push_back(model(f));
        @(negedge clk);
        acc = cyc;
        acc_q.push_back(cyc);
        #1;
        begin_in = 1'b0;
        float_in = 32'hDEAD_BEEF;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("valid_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
            acc_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_vec(input logic [31:0] f, input logic [31:0] fx, input logic ov, input logic un);
        int acc;
        res_t lit;
        lit.fx = fx;
        lit.ov = ov;
        lit.un = un;
        check($sformatf("model_%08h", f), 64'(model(f)), 64'(lit));
        start(f, acc);
        wait_idle();
    endtask

    initial begin
        int a1, a2;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);

        run_vec(32'h3F80_0000, 32'h0400_0000, 1'b0, 1'b0);  // 1.0
        run_vec(32'hBFC0_0000, 32'hFA00_0000, 1'b0, 1'b0);  // -1.5
        run_vec(32'hC200_0000, 32'h8000_0000, 1'b0, 1'b0);  // -32.0 exact
        run_vec(32'h42C8_0000, 32'h7FFF_FFFF, 1'b1, 1'b0);  // 100.0
        run_vec(32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0);  // -Inf
        run_vec(32'h3080_0000, 32'h0000_0000, 1'b0, 1'b1);  // 2^-30
        run_vec(32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0);  // -0
        run_vec(32'h4200_0000, 32'h7FFF_FFFF, 1'b1, 1'b0);  // +32.0
        run_vec(32'hC280_0000, 32'h8000_0000, 1'b1, 1'b0);  // -64.0
        run_vec(32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0);  // +Inf
        run_vec(32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 1'b0);  // NaN
        run_vec(32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1);  // denormal
        run_vec(32'h3F40_0000, 32'h0300_0000, 1'b0, 1'b0);  // 0.75
        run_vec(32'h41FF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0);  // largest below 32
        run_vec(32'hC1FF_FFFF, 32'h8000_0080, 1'b0, 1'b0);
        run_vec(32'h3280_0000, 32'h0000_0001, 1'b0, 1'b0);  // 2^-26 = 1 LSB
`ifdef ROUND_NEAREST_EN
        run_vec(32'h3200_0000, 32'h0000_0001, 1'b0, 1'b0);  // 2^-27 rounds up
        run_vec(32'hB2C0_0000, 32'hFFFF_FFFE, 1'b0, 1'b0);  // -1.5 LSB -> -2
`else
        run_vec(32'h3200_0000, 32'h0000_0000, 1'b0, 1'b1);  // 2^-27 truncates
        run_vec(32'hB2C0_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);  // -1.5 LSB -> -1
`endif

        // Back-to-back conversions: next accept exactly 5 cycles after the previous one.
        start(32'h3F80_0000, a1);
        start(32'hBFC0_0000, a2);
        check("throughput", 64'(a2 - a1), 64'd5);
        wait_idle();

        // BEGIN with a new operand during SHIFT must be ignored.
        start(32'h3F80_0000, a1);
        @(negedge clk);
        #1;
        begin_in = 1'b1;
        float_in = 32'h42C8_0000;
        check("ready_busy", 64'(ready), 64'd0);
        @(negedge clk);
        #1 begin_in = 1'b0;
        wait_idle();
        repeat (6) @(negedge clk);

        // Reset while in SIGN aborts the conversion.
        start(32'h42C8_0000, a1);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (8) @(negedge clk);

        run_vec(32'hBFC0_0000, 32'hFA00_0000, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
